// File: rtl/bin_bcd_convertor.sv
// bin_bcd_convertor: multi-cycle binary <-> packed BCD converter with a
// start/busy/done handshake. The converter processes one bit per clock.
//   mode 0: binary to BCD using shift-add-3 (double dabble)
//   mode 1: BCD to binary using shift-subtract-3, with digit and overflow checks
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request; sampled only while idle (busy == 0)
//   mode              0: bin->bcd, 1: bcd->bin; captured with start
//   bin_in            binary operand (mode 0); captured with start
//   bcd_in            packed BCD operand, digit 0 in [3:0] (mode 1); captured with start
//   busy              conversion in progress
//   done              one-cycle completion pulse
//   bcd_out           mode-0 result; held until the next mode-0 completion
//   bin_out           mode-1 result; held until the next mode-1 completion
//   err               mode 1: an input digit was > 9
//   ovf               mode 1: the BCD value does not fit in BIN_W bits
module bin_bcd_convertor #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err,
    output logic                ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned ACC_W = BIN_W + BCD_W;
    localparam int unsigned N_MAX = (BIN_W > BCD_W) ? BIN_W : BCD_W;
    localparam int unsigned CNT_W = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t state, state_next;

    // Working register: BCD field on top, binary accumulator below.
    // Mode 0 loads the operand into the accumulator's top BIN_W bits.
    // Mode 1 leaves the result as acc_q >> BIN_W after all shifts.
    logic [BCD_W-1:0] bcd_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             bad_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             bcd_invalid;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shr;
    logic [BCD_W-1:0] bcd_sub;
    logic [ACC_W-1:0] value;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        add3 = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) add3[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
    endfunction

    function automatic logic [BCD_W-1:0] sub3(input logic [BCD_W-1:0] v);
        sub3 = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd8) sub3[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
    endfunction

    // Any digit of the incoming BCD operand above 9
    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bcd_invalid = 1'b1;
        end
    end

    // Per-iteration datapath terms for both directions
    always_comb begin
        bcd_adj = add3(bcd_q);
        bcd_shr = {1'b0, bcd_q[BCD_W-1:1]};
        bcd_sub = sub3(bcd_shr);
        value   = acc_q >> BIN_W;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (mode && bcd_invalid) ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) state_next = FIN;
            end
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            bin_out <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                busy   <= 1'b1;
                mode_q <= mode;
                if (mode) begin
                    bcd_q <= bcd_in;
                    acc_q <= '0;
                    cnt_q <= CNT_W'(BCD_W);
                    bad_q <= bcd_invalid;
                end else begin
                    bcd_q <= '0;
                    acc_q <= {bin_in, BCD_W'(0)};
                    cnt_q <= CNT_W'(BIN_W);
                    bad_q <= 1'b0;
                end
            end
            if (step) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (mode_q) begin
                    bcd_q <= bcd_sub;
                    acc_q <= {bcd_q[0], acc_q[ACC_W-1:1]};
                end else begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], acc_q[ACC_W-1]};
                    acc_q <= {acc_q[ACC_W-2:0], 1'b0};
                end
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (mode_q) begin
                    err <= bad_q;
                    if (bad_q) begin
                        bin_out <= '0;
                        ovf     <= 1'b0;
                    end else begin
                        bin_out <= value[BIN_W-1:0];
                        ovf     <= |(value >> BIN_W);
                    end
                end else begin
                    bcd_out <= bcd_q;
                    err     <= 1'b0;
                    ovf     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_bcd_convertor.sv
// tb_bin_bcd_convertor: directed self-checking bench for bin_bcd_convertor
// (BIN_W=8, DIGITS=3).
module tb_bin_bcd_convertor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  bin_in;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [7:0]  bin_out;
    logic        err;
    logic        ovf;

    int n_cmp;
    int n_bad;

    bin_bcd_convertor #(.BIN_W(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .bin_in  (bin_in),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .bin_out (bin_out),
        .err     (err),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then count edges until done (bounded at 40).
    // lat = edges from the start edge to done, -1 on timeout, 0 if aborted by reset.
    task automatic run_conv(input logic m, input logic [7:0] b, input logic [11:0] d,
                            input int glitch_at, input int rst_at,
                            output int lat, output int busy_cyc);
        mode   = m;
        bin_in = b;
        bcd_in = d;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cyc++;
            if (c == glitch_at) begin
                start  = 1'b1;
                bin_in = 8'd99;
                bcd_in = 12'h000;
            end
            if (c == rst_at) rst = 1'b1;
            tick();
            start = 1'b0;
            if (c == rst_at) begin
                rst = 1'b0;
                lat = 0;
                return;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, bcd_out, bin_out, err, ovf} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h bin=%h err=%b ovf=%b, want all 0",
                     busy, done, bcd_out, bin_out, err, ovf);
        end
    endtask

    task automatic test_bin2bcd_255();
        int lat, bc;
        run_conv(1'b0, 8'd255, 12'h000, 0, 0, lat, bc);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL b2b_255_latency: got %0d want 9", lat); end
        n_cmp++;
        if (bc !== 9) begin n_bad++; $display("FAIL b2b_255_busy_cycles: got %0d want 9", bc); end
        n_cmp++;
        if ({bcd_out, ovf, err, busy} !== {12'h255, 3'b000}) begin
            n_bad++;
            $display("FAIL b2b_255_result: got bcd=%h ovf=%b err=%b busy=%b want 255/0/0/0",
                     bcd_out, ovf, err, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_255_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_bcd2bin_199();
        int lat, bc;
        run_conv(1'b1, 8'h00, 12'h199, 0, 0, lat, bc);
        n_cmp++;
        if (lat !== 13) begin n_bad++; $display("FAIL d2b_199_latency: got %0d want 13", lat); end
        n_cmp++;
        if ({bin_out, err, ovf, bcd_out} !== {8'd199, 2'b00, 12'h255}) begin
            n_bad++;
            $display("FAIL d2b_199_result: got bin=%0d err=%b ovf=%b bcd=%h want 199/0/0/255",
                     bin_out, err, ovf, bcd_out);
        end
        tick();
    endtask

    task automatic test_bcd2bin_overflow();
        int lat, bc;
        run_conv(1'b1, 8'h00, 12'h999, 0, 0, lat, bc);
        n_cmp++;
        if (lat !== 13) begin n_bad++; $display("FAIL d2b_999_latency: got %0d want 13", lat); end
        n_cmp++;
        if ({bin_out, err, ovf, bcd_out} !== {8'hE7, 2'b01, 12'h255}) begin
            n_bad++;
            $display("FAIL d2b_999_result: got bin=%h err=%b ovf=%b bcd=%h want e7/0/1/255",
                     bin_out, err, ovf, bcd_out);
        end
        tick();
    endtask

    task automatic test_bad_digit();
        int lat, bc;
        run_conv(1'b1, 8'h00, 12'h1A5, 0, 0, lat, bc);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL d2b_bad_latency: got %0d want 1", lat); end
        n_cmp++;
        if (bc !== 1) begin n_bad++; $display("FAIL d2b_bad_busy_cycles: got %0d want 1", bc); end
        n_cmp++;
        if ({bin_out, err, ovf, busy, bcd_out} !== {8'h00, 3'b100, 12'h255}) begin
            n_bad++;
            $display("FAIL d2b_bad_result: got bin=%h err=%b ovf=%b busy=%b bcd=%h want 00/1/0/0/255",
                     bin_out, err, ovf, busy, bcd_out);
        end
        tick();
        // a following valid conversion must clear err
        run_conv(1'b1, 8'h00, 12'h042, 0, 0, lat, bc);
        n_cmp++;
        if ({lat, bin_out, err, ovf} !== {32'sd13, 8'd42, 2'b00}) begin
            n_bad++;
            $display("FAIL d2b_42_after_err: got lat=%0d bin=%0d err=%b ovf=%b want 13/42/0/0",
                     lat, bin_out, err, ovf);
        end
        tick();
    endtask

    task automatic test_zero_ignore_start();
        int lat, bc;
        run_conv(1'b0, 8'd0, 12'h000, 4, 0, lat, bc);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL b2b_zero_latency: got %0d want 9", lat); end
        n_cmp++;
        if (bcd_out !== 12'h000) begin n_bad++; $display("FAIL b2b_zero_result: got %h want 000", bcd_out); end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_zero_no_queue: busy got %b want 0", busy); end
    endtask

    task automatic test_abort_reset();
        int lat, bc, seen;
        run_conv(1'b0, 8'd37, 12'h000, 0, 4, lat, bc);
        n_cmp++;
        if ({lat, busy, done, bcd_out, bin_out, err, ovf} !== {32'sd0, 26'd0}) begin
            n_bad++;
            $display("FAIL abort_outputs: got lat=%0d busy=%b done=%b bcd=%h bin=%h err=%b ovf=%b want 0",
                     lat, busy, done, bcd_out, bin_out, err, ovf);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        run_conv(1'b0, 8'd128, 12'h000, 0, 0, lat, bc);
        n_cmp++;
        if ({lat, bcd_out} !== {32'sd9, 12'h128}) begin
            n_bad++;
            $display("FAIL abort_then_128: got lat=%0d bcd=%h want 9/128", lat, bcd_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        mode   = 1'b0;
        bin_in = 8'd17;
        start  = 1'b1;
        tick();
        bin_in = 8'd42;
        lat1   = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin lat1 = c; break; end
        end
        n_cmp++;
        if ({lat1, bcd_out} !== {32'sd9, 12'h017}) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d bcd=%h want 9/017", lat1, bcd_out);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept: busy got %b want 1", busy); end
        start = 1'b0;
        lat2  = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done) begin lat2 = c; break; end
        end
        n_cmp++;
        if ({lat2, bcd_out} !== {32'sd9, 12'h042}) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h want 9/042", lat2, bcd_out);
        end
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        bin_in = 8'h00;
        bcd_in = 12'h000;
        test_reset();
        test_bin2bcd_255();
        test_bcd2bin_199();
        test_bcd2bin_overflow();
        test_bad_digit();
        test_zero_ignore_start();
        test_abort_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
